// File: rtl/ula_operand_loader.sv
// Sequences operand A, operand B and the op code from one switch bank and a debounced ENTER button.
// Issues one go pulse to the ULA and latches its result for the LEDs.
module ula_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clr,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic [2:0] sel_out,
  output logic       go,
  input  logic [3:0] result_in,
  output logic [3:0] result_q,
  output logic [2:0] stage,
  output logic       op_err
);

  typedef enum logic [2:0] {StLoadA, StLoadB, StLoadOp, StExec, StCapt, StShow} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is ENTER, bit 1 is CLEAR.
  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync2_q, filt_q, filt_d, filt_prev_q, press;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0] sel_q, sel_d;
  logic       go_q, go_d, err_q, err_d;

  assign raw   = {btn_clr, btn_enter};
  assign press = filt_q & ~filt_prev_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CntMax) filt_d[i] = sync2_q[i];
        else                    cnt_d[i]  = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    go_d    = 1'b0;
    err_d   = 1'b0;
    // CLEAR outranks ENTER; operands are deliberately kept.
    if (press[1]) begin
      state_d = StLoadA;
      res_d   = '0;
    end else begin
      case (state_q)
        StLoadA: if (press[0]) begin
          a_d     = sw;
          state_d = StLoadB;
        end
        StLoadB: if (press[0]) begin
          b_d     = sw;
          state_d = StLoadOp;
        end
        StLoadOp: if (press[0]) begin
          if (sw[2:0] <= 3'd5) begin
            sel_d   = sw[2:0];
            go_d    = 1'b1;
            state_d = StExec;
          end else begin
            err_d = 1'b1;
          end
        end
        StExec: state_d = StCapt;
        StCapt: begin
          res_d   = result_in;
          state_d = StShow;
        end
        StShow: if (press[0]) state_d = StLoadA;
        default: state_d = StLoadA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoadA;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      go_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      go_q    <= go_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    case (state_q)
      StLoadA:  stage = 3'b001;
      StLoadB:  stage = 3'b010;
      StLoadOp: stage = 3'b100;
      default:  stage = 3'b000;
    endcase
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign sel_out  = sel_q;
  assign result_q = res_q;
  assign go       = go_q;
  assign op_err   = err_q;

endmodule

// File: tb/tb_ula_operand_loader.sv
// Bench for ula_operand_loader: scoreboard of expected {A,B,op,result} checked at each go pulse,
// a table of full entry sequences, and hand-written bounce/CLEAR/reset corner cases.
module tb_ula_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic       btn_enter = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] a_out, b_out, result_q, result_in;
  logic [2:0] sel_out, stage;
  logic       go, op_err;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_push = 0;
  int   go_cnt = 0;
  int   err_cnt = 0;

  ula_operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn_enter(btn_enter),
    .btn_clr  (btn_clr),
    .a_out    (a_out),
    .b_out    (b_out),
    .sel_out  (sel_out),
    .go       (go),
    .result_in(result_in),
    .result_q (result_q),
    .stage    (stage),
    .op_err   (op_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic press(input logic [3:0] v, input int hold);
    @(negedge clk);
    sw        = v;
    btn_enter = 1'b1;
    repeat (hold) @(negedge clk);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic [3:0] res);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res;
    exp_q.push_back(v);
    n_push++;
  endtask

  // Scoreboard: on go, compare operands, then drive the ULA result only during CAPT so a
  // capture on the wrong cycle sees the inverted value.
  initial begin
    vec_t e;
    result_in = 4'h0;
    forever begin
      @(negedge clk);
      if (op_err) err_cnt++;
      if (go) begin
        go_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_go", 8'd1, 8'd0);
        end else begin
          e = exp_q.pop_front();
          check("go_a", {4'h0, a_out}, {4'h0, e.a});
          check("go_b", {4'h0, b_out}, {4'h0, e.b});
          check("go_sel", {5'h0, sel_out}, {5'h0, e.op});
          result_in = ~e.res;
          @(negedge clk);
          check("go_width", {7'h0, go}, 8'd0);
          result_in = e.res;
          @(negedge clk);
          check("result_latency", {4'h0, result_q}, {4'h0, e.res});
          result_in = ~e.res;
        end
      end
    end
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{a: 4'd6,  b: 4'd3, op: 3'd0, res: 4'd2};
    vecs[1] = '{a: 4'd5,  b: 4'd3, op: 3'd1, res: 4'd7};
    vecs[2] = '{a: 4'd7,  b: 4'd9, op: 3'd2, res: 4'd0};
    vecs[3] = '{a: 4'd2,  b: 4'd5, op: 3'd3, res: 4'd13};
    vecs[4] = '{a: 4'd3,  b: 4'd5, op: 3'd4, res: 4'd15};
    vecs[5] = '{a: 4'd12, b: 4'd4, op: 3'd5, res: 4'd3};

    repeat (3) @(negedge clk);
    check("rst_a", {4'h0, a_out}, 8'd0);
    check("rst_b", {4'h0, b_out}, 8'd0);
    check("rst_sel", {5'h0, sel_out}, 8'd0);
    check("rst_res", {4'h0, result_q}, 8'd0);
    check("rst_go", {7'h0, go}, 8'd0);
    check("rst_err", {7'h0, op_err}, 8'd0);
    check("rst_stage", {5'h0, stage}, 8'b001);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic entry: 3 + 2.
    press(4'd3, 10);
    check("t1_a", {4'h0, a_out}, 8'd3);
    check("t1_stage_b", {5'h0, stage}, 8'b010);
    press(4'd2, 10);
    check("t1_b", {4'h0, b_out}, 8'd2);
    check("t1_stage_op", {5'h0, stage}, 8'b100);
    push(4'd3, 4'd2, 3'd2, 4'd5);
    press(4'd2, 10);
    check("t1_sel", {5'h0, sel_out}, 8'd2);
    check("t1_res", {4'h0, result_q}, 8'd5);
    check("t1_stage_show", {5'h0, stage}, 8'b000);
    check("t1_go_cnt", 8'(go_cnt), 8'd1);

    // SHOW -> LOAD_A.
    press(4'd15, 10);
    check("t6_stage", {5'h0, stage}, 8'b001);
    check("t6_a_kept", {4'h0, a_out}, 8'd3);

    // Bounce glitches shorter than the debounce window, then a long hold.
    sw = 4'd9;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk); btn_enter = 1'b1;
      repeat (3) @(negedge clk); btn_enter = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("t2_glitch_stage", {5'h0, stage}, 8'b001);
    check("t2_glitch_a", {4'h0, a_out}, 8'd3);
    press(4'd9, 20);
    check("t2_stage", {5'h0, stage}, 8'b010);
    check("t2_a", {4'h0, a_out}, 8'd9);
    check("t6_b_kept", {4'h0, b_out}, 8'd2);
    check("t6_sel_kept", {5'h0, sel_out}, 8'd2);

    // Rejected op codes.
    press(4'd1, 10);
    press(4'd6, 10);
    press(4'd7, 10);
    check("t3_err_cnt", 8'(err_cnt), 8'd2);
    check("t3_stage", {5'h0, stage}, 8'b100);
    check("t3_sel_kept", {5'h0, sel_out}, 8'd2);
    check("t3_no_go", 8'(go_cnt), 8'd1);
    push(4'd9, 4'd1, 3'd5, 4'd9);
    press(4'd5, 10);
    check("t3_sel", {5'h0, sel_out}, 8'd5);
    check("t3_res", {4'h0, result_q}, 8'd9);

    // Table of full sequences, each starting from SHOW.
    for (int i = 0; i < 6; i++) begin
      press(4'd0, 10);
      press(vecs[i].a, 10);
      press(vecs[i].b, 10);
      push(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res);
      press({1'b0, vecs[i].op}, 10);
      check($sformatf("vec%0d_res", i), {4'h0, result_q}, {4'h0, vecs[i].res});
      check($sformatf("vec%0d_stage", i), {5'h0, stage}, 8'b000);
    end

    // CLEAR and ENTER together in LOAD_B.
    press(4'd0, 10);
    press(4'd8, 10);
    check("t4_pre_stage", {5'h0, stage}, 8'b010);
    @(negedge clk);
    sw = 4'd11; btn_enter = 1'b1; btn_clr = 1'b1;
    repeat (10) @(negedge clk);
    btn_enter = 1'b0; btn_clr = 1'b0;
    repeat (12) @(negedge clk);
    check("t4_stage", {5'h0, stage}, 8'b001);
    check("t4_res", {4'h0, result_q}, 8'd0);
    check("t4_b_kept", {4'h0, b_out}, 8'd4);
    check("t4_a_kept", {4'h0, a_out}, 8'd8);

    // Asynchronous reset in LOAD_OP, off the clock edge.
    press(4'd1, 10);
    press(4'd2, 10);
    check("t5_pre_stage", {5'h0, stage}, 8'b100);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_a", {4'h0, a_out}, 8'd0);
    check("t5_b", {4'h0, b_out}, 8'd0);
    check("t5_sel", {5'h0, sel_out}, 8'd0);
    check("t5_stage", {5'h0, stage}, 8'b001);
    check("t5_go", {7'h0, go}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("end_queue_empty", 8'(exp_q.size()), 8'd0);
    check("end_go_cnt", 8'(go_cnt), 8'(n_push));
    check("end_err_cnt", 8'(err_cnt), 8'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
